neuron_mac_act: RTL and testbench
=================================

Name: neuron_mac_act

Overview:
- Neuron datapath directly downstream of the accumulator control FSM.
- Consumes its per-term strobes: sel = first term of a group, load; en = last term of a group, commit.
- Performs signed multiply-accumulate of pixel/activation × weight with bias preload and a saturating accumulator.
- Applies arithmetic right-shift rescale, ReLU and unsigned output clipping; emits one result per group to the next layer / argmax stage.

Parameters:
- DATA_W, 8: signed input activation width.
- WGT_W, 8: signed weight width.
- ACC_W, 20: signed accumulator and bias width (must be >= DATA_W+WGT_W+2).
- OUT_W, 8: unsigned output activation width.
- FRAC_SHIFT, 7: arithmetic right shift applied to the accumulator before activation.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- sel  input  1  term is first of group: load bias + product.
- en  input  1  term is last of group: commit result.
- x_in  input  DATA_W  signed activation, one term per cycle.
- w_in  input  WGT_W  signed weight, aligned with x_in.
- bias_in  input  ACC_W  signed bias; sampled only on cycles with sel=1.
- out_data  output  OUT_W  unsigned activated neuron output.
- out_valid  output  1  one-cycle pulse, out_data valid.
- sat_flag  output  1  accumulator saturated at least once in the reported group; valid with out_valid.

Behaviour:
- Reset (reset=0 at a rising edge):
  - Outputs: out_data=0, out_valid=0, sat_flag=0.
  - Internal: accumulator=0, pipeline product=0, all pipeline sel/en copies=0, sticky sat=0.
- Every cycle is a term; there is no stall input. sel/en/x_in/w_in/bias_in are sampled on every rising edge.
- Stage 1 (edge E0):
  - p1 = x_in*w_in, full DATA_W+WGT_W signed, sign-extended to ACC_W.
  - Register sel1, en1 and bias1 (bias1 captured only when sel=1).
- Stage 2 (edge E1):
  - Base b = sel1 ? bias1 : acc.
  - acc = sat_add(b, p1), clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - sat_st = (sel1 ? 0 : sat_st) | overflow.
  - If en1: fin = new acc, fsat = new sat_st, v2=1; else v2=0.
- Stage 3 (edge E2):
  - If v2: s = fin >>> FRAC_SHIFT (arithmetic, floor).
  - out_data = s<0 ? 0 : (s > 2^OUT_W-1 ? 2^OUT_W-1 : s).
  - sat_flag = fsat, out_valid = 1.
  - Else out_valid=0; out_data and sat_flag hold their last values.
- Latency: en presented in cycle T -> out_valid=1 in cycle T+2 exactly. Throughput: one group may commit every cycle.
- Boundary cases:
  - sel=1 and en=1 same cycle: single-term group; result is bias+p.
  - sel=1 without a preceding en: the open group is discarded silently; no output.
  - en=1 without any prior sel since reset: commits acc (0 after reset) + p; the bias term is absent.
  - Consecutive en cycles with no sel: each commits a running partial sum.
  - Saturated accumulator stays clamped; later terms add from the clamped value.
  - Reset mid-group: the in-flight group and any pending out_valid are dropped; no out_valid in the cycle after reset deasserts.
- FSM pattern from the control block: sel at state 0, en at state 3, giving 4-term groups with an output every 4 cycles.

Decomposition:
- Package nn_pkg holds:
  - Default widths DATA_W, WGT_W, ACC_W, OUT_W, FRAC_SHIFT.
  - Signed accumulator typedef acc_t.
  - Constants ACC_MAX/ACC_MIN and OUT_MAX.
- One sub-module sat_add_acc: combinational ACC_W signed saturating adder, outputs sum and overflow. Instantiated in stage 2.
- Stages 1 and 3 are inline.

Test Plan:
- 4-term group, sel at term 0 and en at term 3, bias=0, x=[10,20,30,40], w=[1,2,3,4]:
  - Sum 300, 300>>>7 = 2.
  - out_data=2, sat_flag=0, out_valid exactly 2 cycles after the en cycle.
- Negative result, bias=0, x=[10,10,10,10], w=[-5,-5,-5,-5]:
  - Sum -200, -200>>>7 = -2.
  - ReLU gives out_data=0.
- Output clip, bias=0, x=127, w=127 for 4 terms:
  - Sum 64516, 64516>>>7 = 504.
  - out_data=255, sat_flag=0.
- Accumulator saturation, bias=524000, single-term group (sel=en=1), x=127, w=127:
  - acc clamps to 524287.
  - out_data=255, sat_flag=1.
  - A following normal group reports sat_flag=0.
- Back-to-back single-term groups every cycle with x=k, w=1, bias=0:
  - Outputs 0,0,..., since k<128 floors to 0.
  - Repeat with bias=128·k: out_data=k each cycle; out_valid held high continuously.
- Assert reset=0 for one cycle two cycles after a group's en:
  - The group's out_valid is suppressed.
  - All outputs read 0 after the reset edge.
  - Next group produces the correct value.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared widths, accumulator type and saturation / clip constants for the
// neuron datapath.
package nn_pkg;

  localparam int DATA_W     = 8;   // signed activation width
  localparam int WGT_W      = 8;   // signed weight width
  localparam int ACC_W      = 20;  // signed accumulator / bias width
  localparam int OUT_W      = 8;   // unsigned output activation width
  localparam int FRAC_SHIFT = 7;   // rescale shift before activation

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam int   OUT_MAX = (1 << OUT_W) - 1;

endpackage

// File: rtl/sat_add_acc.sv
// Combinational signed saturating adder for the accumulator.
// Ports:
//   a, b     : W-bit signed addends
//   sum      : a+b clamped to [-2^(W-1), 2^(W-1)-1]
//   overflow : 1 when the true sum fell outside that range
module sat_add_acc #(
  parameter int W = nn_pkg::ACC_W
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                overflow
);
  import nn_pkg::*;

  logic [W:0] wide;

  always_comb begin
    wide     = {a[W-1], a} + {b[W-1], b};
    // one guard bit: overflow iff it disagrees with the result sign bit
    overflow = wide[W] ^ wide[W-1];
    if (overflow) begin
      sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end else begin
      sum = wide[W-1:0];
    end
  end

endmodule

// File: rtl/neuron_mac_act.sv
// Neuron datapath: signed MAC with bias preload, saturating accumulator,
// arithmetic rescale, ReLU and unsigned clip. One result per group.
// Pipeline: stage 1 multiply, stage 2 accumulate, stage 3 activate.
// Ports:
//   clk       : clock, rising edge
//   reset     : synchronous active-low reset
//   sel       : first term of group (load bias + product)
//   en        : last term of group (commit)
//   x_in      : signed activation
//   w_in      : signed weight
//   bias_in   : signed bias, sampled when sel=1
//   out_data  : unsigned activated output
//   out_valid : one-cycle pulse, out_data/sat_flag valid
//   sat_flag  : accumulator saturated during the reported group
module neuron_mac_act #(
  parameter int DATA_W     = nn_pkg::DATA_W,
  parameter int WGT_W      = nn_pkg::WGT_W,
  parameter int ACC_W      = nn_pkg::ACC_W,
  parameter int OUT_W      = nn_pkg::OUT_W,
  parameter int FRAC_SHIFT = nn_pkg::FRAC_SHIFT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sel,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [WGT_W-1:0]  w_in,
  input  logic signed [ACC_W-1:0]  bias_in,
  output logic        [OUT_W-1:0]  out_data,
  output logic                     out_valid,
  output logic                     sat_flag
);
  import nn_pkg::*;

  localparam int PROD_W = DATA_W + WGT_W;
  localparam logic signed [ACC_W-1:0] OUT_CLIP = ACC_W'((1 << OUT_W) - 1);

  // stage 1
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  p1;
  logic signed [ACC_W-1:0]  bias1;
  logic                     sel1;
  logic                     en1;

  // stage 2
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  acc_sum;
  logic                     acc_ovf;
  logic                     sat_st;
  logic                     sat_next;
  logic signed [ACC_W-1:0]  fin;
  logic                     fsat;
  logic                     v2;

  // stage 3
  logic signed [ACC_W-1:0]  shifted;
  logic        [OUT_W-1:0]  act_val;

  // operands widened first so the product keeps its full signed width
  assign prod = PROD_W'(x_in) * PROD_W'(w_in);

  always_ff @(posedge clk) begin
    if (!reset) begin
      p1    <= '0;
      bias1 <= '0;
      sel1  <= 1'b0;
      en1   <= 1'b0;
    end else begin
      p1   <= ACC_W'(prod);
      sel1 <= sel;
      en1  <= en;
      if (sel) begin
        bias1 <= bias_in;
      end
    end
  end

  // a group start discards whatever the accumulator held
  assign base     = sel1 ? bias1 : acc;
  assign sat_next = (sel1 ? 1'b0 : sat_st) | acc_ovf;

  sat_add_acc #(.W(ACC_W)) u_sat_add (
    .a        (base),
    .b        (p1),
    .sum      (acc_sum),
    .overflow (acc_ovf)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc    <= '0;
      sat_st <= 1'b0;
      fin    <= '0;
      fsat   <= 1'b0;
      v2     <= 1'b0;
    end else begin
      acc    <= acc_sum;
      sat_st <= sat_next;
      v2     <= en1;
      if (en1) begin
        fin  <= acc_sum;
        fsat <= sat_next;
      end
    end
  end

  always_comb begin
    shifted = fin >>> FRAC_SHIFT;
    act_val = '0;
    if (shifted < 0) begin
      act_val = '0;
    end else if (shifted > OUT_CLIP) begin
      act_val = '1;
    end else begin
      act_val = shifted[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      out_valid <= v2;
      if (v2) begin
        out_data <= act_val;
        sat_flag <= fsat;
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac_act.sv
// Bench for neuron_mac_act: table of whole groups plus hand sequences for
// partial sums, discarded groups, clamping and reset; expected outputs are
// queued with their due cycle and compared by a negedge monitor.
module tb_neuron_mac_act;
  import nn_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     sel;
  logic                     en;
  logic signed [DATA_W-1:0] x_in;
  logic signed [WGT_W-1:0]  w_in;
  logic signed [ACC_W-1:0]  bias_in;
  logic        [OUT_W-1:0]  out_data;
  logic                     out_valid;
  logic                     sat_flag;

  always #5 clk = ~clk;

  neuron_mac_act dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .en        (en),
    .x_in      (x_in),
    .w_in      (w_in),
    .bias_in   (bias_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .sat_flag  (sat_flag)
  );

  typedef struct {
    int due;
    int data;
    bit sat;
  } exp_t;

  typedef struct {
    int n;
    int bias;
    int x [4];
    int w [4];
    int exp_data;
    bit exp_sat;
  } grp_t;

  exp_t   q [$];
  exp_t   e_cur;
  int     cyc = 0;
  int     n_checks = 0;
  int     n_err = 0;
  bit     mon_on = 1'b0;
  int     last_d = 0;
  bit     last_s = 1'b0;
  longint acc_m = 0;
  bit     sat_m = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic signed [63:0] act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int act_fn(input longint v);
    longint s;
    s = v >>> FRAC_SHIFT;
    if (s < 0) return 0;
    if (s > OUT_MAX) return OUT_MAX;
    return int'(s);
  endfunction

  // One term; exp_d < 0 means take the expected result from the model.
  task automatic term(input bit s, input bit e, input int x, input int w,
                      input int b, input int exp_d, input bit exp_s);
    longint sum;
    bit     ovf;
    exp_t   ex;
    sel     = s;
    en      = e;
    x_in    = DATA_W'(x);
    w_in    = WGT_W'(w);
    bias_in = ACC_W'(b);
    sum = (s ? longint'(b) : acc_m) + longint'(x) * longint'(w);
    ovf = 1'b0;
    if (sum > ACC_MAX) begin sum = ACC_MAX; ovf = 1'b1; end
    if (sum < ACC_MIN) begin sum = ACC_MIN; ovf = 1'b1; end
    sat_m = (s ? 1'b0 : sat_m) | ovf;
    acc_m = sum;
    if (e) begin
      ex.due = cyc + 3;
      if (exp_d < 0) begin
        ex.data = act_fn(sum);
        ex.sat  = sat_m;
      end else begin
        ex.data = exp_d;
        ex.sat  = exp_s;
      end
      q.push_back(ex);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    term(1'b0, 1'b0, 0, 0, 0, -1, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    sel   = 1'b0;
    en    = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sat_flag", sat_flag, 0);
    reset  = 1'b1;
    acc_m  = 0;
    sat_m  = 1'b0;
    last_d = 0;
    last_s = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (q.size() != 0 && q[0].due == cyc) begin
        e_cur = q.pop_front();
        chk("out_valid", out_valid, 1);
        chk("out_data", out_data, e_cur.data);
        chk("sat_flag", sat_flag, e_cur.sat);
        last_d = e_cur.data;
        last_s = e_cur.sat;
      end else begin
        chk("no_valid", out_valid, 0);
        chk("hold_data", out_data, last_d);
        chk("hold_sat", sat_flag, last_s);
      end
    end
  end

  grp_t tbl [8];

  initial begin
    tbl[0] = '{4, 0,       '{10, 20, 30, 40},     '{1, 2, 3, 4},         2,   1'b0};
    tbl[1] = '{4, 0,       '{10, 10, 10, 10},     '{-5, -5, -5, -5},     0,   1'b0};
    tbl[2] = '{4, 0,       '{127, 127, 127, 127}, '{127, 127, 127, 127}, 255, 1'b0};
    tbl[3] = '{1, 524000,  '{127, 0, 0, 0},       '{127, 0, 0, 0},       255, 1'b1};
    tbl[4] = '{4, 1000,    '{-3, 5, 7, -9},       '{2, -4, 6, 8},        7,   1'b0};
    tbl[5] = '{4, -524288, '{-128, -128, -128, -128}, '{127, 127, 127, 127}, 0, 1'b1};
    tbl[6] = '{4, 32768,   '{0, 0, 0, 0},         '{0, 0, 0, 0},         255, 1'b0};
    tbl[7] = '{1, 200,     '{5, 0, 0, 0},         '{-8, 0, 0, 0},        1,   1'b0};

    reset   = 1'b0;
    sel     = 1'b0;
    en      = 1'b0;
    x_in    = '0;
    w_in    = '0;
    bias_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_out_valid", out_valid, 0);
    chk("init_out_data", out_data, 0);
    chk("init_sat_flag", sat_flag, 0);
    reset  = 1'b1;
    mon_on = 1'b1;

    // en with no sel since reset, then a second en: running partial sums
    term(1'b0, 1'b1, 3, 50, 0, -1, 1'b0);
    term(1'b0, 1'b1, 3, 50, 0, -1, 1'b0);
    idle();

    // whole groups; non-sel terms carry a junk bias that must be ignored
    for (int i = 0; i < 8; i++) begin
      for (int t = 0; t < tbl[i].n; t++) begin
        term(t == 0, t == tbl[i].n - 1, tbl[i].x[t], tbl[i].w[t],
             (t == 0) ? tbl[i].bias : tbl[i].bias + 77,
             (t == tbl[i].n - 1) ? tbl[i].exp_data : -1, tbl[i].exp_sat);
      end
    end

    // open group abandoned by a new sel
    term(1'b1, 1'b0, 50, 50, 999, -1, 1'b0);
    term(1'b1, 1'b1, 2, 64, 0, 1, 1'b0);

    // single-term groups every cycle
    for (int k = 1; k <= 20; k++) term(1'b1, 1'b1, k, 1, 0, 0, 1'b0);
    for (int k = 1; k <= 20; k++) term(1'b1, 1'b1, k, 1, 128 * k, k, 1'b0);
    idle();

    // commits of a running sum without sel
    term(1'b1, 1'b0, 100, 100, 0, -1, 1'b0);
    term(1'b0, 1'b1, 100, 100, 0, 156, 1'b0);
    term(1'b0, 1'b1, 100, 100, 0, 234, 1'b0);
    term(1'b0, 1'b1, 100, 100, 0, 255, 1'b0);

    // clamp at max, then later terms subtract from the clamped value
    term(1'b1, 1'b0, 127, 127, 524000, -1, 1'b0);
    for (int k = 0; k < 31; k++) term(1'b0, k == 30, -128, 127, 0, (k == 30) ? 158 : -1, 1'b1);
    term(1'b1, 1'b1, 10, 10, 0, 0, 1'b0);

    // reset two cycles after en drops the pending result
    for (int t = 0; t < 4; t++) term(t == 0, t == 3, tbl[0].x[t], tbl[0].w[t], 0, -1, 1'b0);
    idle();
    do_reset();
    for (int t = 0; t < 4; t++) term(t == 0, t == 3, tbl[0].x[t], tbl[0].w[t], 0, 2, 1'b0);

    repeat (5) idle();
    chk("drain_pending", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
